// File: rtl/sync_pkg.sv
// Shared types and constants for the sync signal generator and its trigger meter.
package sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEAD     = 3'd1,
    ST_FG_PULSE = 3'd2,
    ST_BURST    = 3'd3,
    ST_DONE     = 3'd4
  } sync_gen_state_t;

  localparam int              MEAS_W   = 16;
  localparam logic [MEAS_W-1:0] MEAS_SAT = 16'hFFFF;

  function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
    return (v == MEAS_SAT) ? v : v + MEAS_W'(1);
  endfunction

endpackage

// File: rtl/sync_trigger_meter.sv
// Measures the returned trigger: delay from the last phase front to its rise,
// and its high time; results are presented on the trigger fall.
module sync_trigger_meter
  import sync_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger_in,
  input  logic              phase_front,
  output logic [MEAS_W-1:0] meas_delay,
  output logic [MEAS_W-1:0] meas_width,
  output logic              meas_valid
);

  logic              trig_q, trig_prev_q;
  logic              trig_rise, trig_fall;
  logic [MEAS_W-1:0] dly_q, dly_d, dly_lat_q;
  logic [MEAS_W-1:0] wid_q, wid_d;
  logic [MEAS_W-1:0] meas_delay_q, meas_width_q;
  logic              meas_valid_q;

  assign trig_rise = trig_q & ~trig_prev_q;
  assign trig_fall = ~trig_q & trig_prev_q;

  // The trigger is one register behind the phase front, so the rise latches
  // the next counter value; a rise coinciding with a front latches 0.
  assign dly_d = phase_front ? '0 : sat_inc(dly_q);

  always_comb begin
    wid_d = wid_q;
    if (trig_rise) begin
      wid_d = MEAS_W'(1);
    end else if (trig_q) begin
      wid_d = sat_inc(wid_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_q       <= 1'b0;
      trig_prev_q  <= 1'b0;
      dly_q        <= MEAS_SAT;
      dly_lat_q    <= '0;
      wid_q        <= '0;
      meas_delay_q <= '0;
      meas_width_q <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      trig_q       <= trigger_in;
      trig_prev_q  <= trig_q;
      dly_q        <= dly_d;
      wid_q        <= wid_d;
      meas_valid_q <= trig_fall;
      if (trig_rise) begin
        dly_lat_q <= dly_d;
      end
      if (trig_fall) begin
        meas_delay_q <= dly_lat_q;
        meas_width_q <= wid_q;
      end
    end
  end

  assign meas_delay = meas_delay_q;
  assign meas_width = meas_width_q;
  assign meas_valid = meas_valid_q;

endmodule

// File: rtl/sync_signal_generator.sv
// Calibration-path emulator: fg pulse, free-running phase train, burst FSM.
// Trigger measurement is compiled in only when SYNC_GEN_MEASURE_EN is defined.
module sync_signal_generator
  import sync_pkg::*;
#(
  parameter int FG_LEAD      = 1000,
  parameter int FG_WIDTH     = 50,
  parameter int PHASE_PERIOD = 2000,
  parameter int PHASE_WIDTH  = 10,
  parameter int BURST_LEN    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        arm,
  input  logic        abort,
  input  logic        trigger_in,
  output logic        fg_signal,
  output logic        phase_signal,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_out,
  output logic [15:0] meas_delay,
  output logic [15:0] meas_width,
  output logic        meas_valid
);

  logic            en_q;
  logic [31:0]     phase_cnt_q;
  logic            phase_q, phase_prev_q;
  logic            phase_front;
  logic            arm_q, arm_prev_q, arm_rise_q;
  sync_gen_state_t state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;

  assign phase_front = phase_q & ~phase_prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q         <= 1'b0;
      phase_cnt_q  <= '0;
      phase_q      <= 1'b0;
      phase_prev_q <= 1'b0;
      arm_q        <= 1'b0;
      arm_prev_q   <= 1'b0;
      arm_rise_q   <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
    end else begin
      en_q         <= enable;
      phase_q      <= en_q && (phase_cnt_q < 32'(PHASE_WIDTH));
      phase_prev_q <= phase_q;
      if (!en_q || phase_cnt_q == 32'(PHASE_PERIOD - 1)) begin
        phase_cnt_q <= '0;
      end else begin
        phase_cnt_q <= phase_cnt_q + 32'd1;
      end
      // Registered arm edge places LEAD entry two clocks after arm is sampled.
      arm_q        <= arm;
      arm_prev_q   <= arm_q;
      arm_rise_q   <= arm_q & ~arm_prev_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_rise_q) begin
            state_d = ST_LEAD;
            cnt_d   = '0;
          end
        end
        ST_LEAD: begin
          if (cnt_q == 32'(FG_LEAD - 1)) begin
            state_d = ST_FG_PULSE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_FG_PULSE: begin
          if (cnt_q == 32'(FG_WIDTH - 1)) begin
            state_d = ST_BURST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_BURST: begin
          // cnt_q counts phase fronts here; no fronts arrive while enable is low.
          if (phase_front) begin
            if (cnt_q == 32'(BURST_LEN - 1)) begin
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign fg_signal    = (state_q == ST_FG_PULSE);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign state_out    = state_q;
  assign phase_signal = phase_q;

`ifdef SYNC_GEN_MEASURE_EN
  sync_trigger_meter u_meter (
    .clock       (clock),
    .reset       (reset),
    .trigger_in  (trigger_in),
    .phase_front (phase_front),
    .meas_delay  (meas_delay),
    .meas_width  (meas_width),
    .meas_valid  (meas_valid)
  );
`else
  logic trigger_unused;
  assign trigger_unused = trigger_in;
  assign meas_delay     = '0;
  assign meas_width     = '0;
  assign meas_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_sync_signal_generator.sv
// Bench for sync_signal_generator: timeline model of phase/burst behaviour
// plus randomized trigger pulses with expected measurements.
module tb_sync_signal_generator;

  localparam int L  = 5;
  localparam int FW = 4;
  localparam int P  = 20;
  localparam int PW = 3;
  localparam int BL = 3;
`ifdef SYNC_GEN_MEASURE_EN
  localparam bit MEAS_ON = 1'b1;
`else
  localparam bit MEAS_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trigger_in = 1'b0;
  logic        fg_signal, phase_signal, busy, done, meas_valid;
  logic [2:0]  state_out;
  logic [15:0] meas_delay, meas_width;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int en_edge = -1;
  logic [31:0] exp_q[$];

  sync_signal_generator #(
    .FG_LEAD(L), .FG_WIDTH(FW), .PHASE_PERIOD(P), .PHASE_WIDTH(PW), .BURST_LEN(BL)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .arm(arm), .abort(abort),
    .trigger_in(trigger_in), .fg_signal(fg_signal), .phase_signal(phase_signal),
    .busy(busy), .done(done), .state_out(state_out), .meas_delay(meas_delay),
    .meas_width(meas_width), .meas_valid(meas_valid)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: phase high for PW of every P edges, starting one edge after enable is sampled
  function automatic bit exp_phase(input int t);
    if (en_edge < 0 || t < en_edge + 1) return 1'b0;
    return ((t - en_edge - 1) % P) < PW;
  endfunction

  function automatic int next_front(input int t);
    int base;
    base = en_edge + 1;
    if (t <= base) return base;
    return base + ((t - base + P - 1) / P) * P;
  endfunction

  always @(negedge clock) check("phase", phase_signal, exp_phase(cyc));

  // driver tasks
  task automatic run_burst(input bit second_arm);
    int gap, hold, k, b0, fg0, bs, d_edge, n_done;
    logic [2:0] es;
    gap = $urandom_range(0, 10);
    repeat (gap) @(negedge clock);
    hold = $urandom_range(1, 3);
    arm = 1'b1;
    k = cyc + 1;
    b0 = k + 2;
    fg0 = b0 + L;
    bs = fg0 + FW;
    d_edge = next_front(bs) + (BL - 1) * P + 1;
    n_done = 0;
    while (cyc < d_edge + 2) begin
      @(negedge clock);
      if (cyc == k + hold - 1) arm = 1'b0;
      if (second_arm && cyc == bs + 1) arm = 1'b1;
      if (second_arm && cyc == bs + 2) arm = 1'b0;
      if (cyc < b0)          es = 3'd0;
      else if (cyc < fg0)    es = 3'd1;
      else if (cyc < bs)     es = 3'd2;
      else if (cyc < d_edge) es = 3'd3;
      else if (cyc == d_edge) es = 3'd4;
      else                   es = 3'd0;
      check("state", state_out, es);
      check("fg", fg_signal, (cyc >= fg0 && cyc < bs));
      check("busy", busy, (es != 3'd0));
      check("done", done, (cyc == d_edge));
      if (done) n_done++;
    end
    check("done_count", n_done, 1);
  endtask

  task automatic trig_pulse(input int n_edge, input int w, input logic [31:0] e_dly);
    while (cyc < n_edge - 1) @(negedge clock);
    trigger_in = 1'b1;
    exp_q.push_back(MEAS_ON ? e_dly : 32'd0);
    exp_q.push_back(MEAS_ON ? 32'(w) : 32'd0);
    while (cyc < n_edge + w - 1) @(negedge clock);
    trigger_in = 1'b0;
    @(negedge clock);
    check("meas_valid_early", meas_valid, 1'b0);
    @(negedge clock);
    check("meas_valid", meas_valid, MEAS_ON);
    check("meas_delay", meas_delay, exp_q.pop_front());
    check("meas_width", meas_width, exp_q.pop_front());
    @(negedge clock);
    check("meas_valid_1cyc", meas_valid, 1'b0);
  endtask

  task automatic abort_test();
    int k, fg0;
    arm = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    arm = 1'b0;
    fg0 = k + 2 + L;
    while (cyc < fg0 + 1) @(negedge clock);
    check("abort_pre_fg", fg_signal, 1'b1);
    abort = 1'b1;
    @(negedge clock);
    check("abort_fg", fg_signal, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_state", state_out, 3'd0);
    abort = 1'b0;
    repeat (3) @(negedge clock);
    // abort held across a fresh arm edge must keep the FSM idle
    abort = 1'b1;
    arm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      arm = 1'b0;
      check("abort_arm_busy", busy, 1'b0);
    end
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_arm_state", state_out, 3'd0);
    end
  endtask

  task automatic reset_mid_test();
    int k, bs;
    arm = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    arm = 1'b0;
    bs = k + 2 + L + FW;
    while (cyc < bs + 3) @(negedge clock);
    check("rst_pre_state", state_out, 3'd3);
    trigger_in = 1'b1;
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b1;
    en_edge = -1;
    #1;
    check("rst_fg", fg_signal, 1'b0);
    check("rst_phase", phase_signal, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", state_out, 3'd0);
    check("rst_meas_valid", meas_valid, 1'b0);
    check("rst_meas_delay", meas_delay, 16'd0);
    check("rst_meas_width", meas_width, 16'd0);
    @(negedge clock);
    trigger_in = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    en_edge = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rst_no_partial", meas_valid, 1'b0);
      check("rst_post_state", state_out, 3'd0);
    end
  endtask

  // main sequence
  initial begin
    repeat (3) @(negedge clock);
    check("reset_fg", fg_signal, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_state", state_out, 3'd0);
    check("reset_meas_valid", meas_valid, 1'b0);
    check("reset_meas_delay", meas_delay, 16'd0);
    check("reset_meas_width", meas_width, 16'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_state", state_out, 3'd0);

    trig_pulse(cyc + 3, $urandom_range(1, 4), 32'hFFFF);

    enable = 1'b1;
    en_edge = cyc + 1;
    repeat (45) @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      int d, w, f;
      d = (i == 0) ? 7 : (i == 1) ? 0 : $urandom_range(0, P - 1);
      w = (i == 0) ? 5 : (i == 1) ? 1 : $urandom_range(1, 8);
      f = next_front(cyc + 2);
      trig_pulse(f + d, w, 32'(d));
    end

    run_burst(1'b1);
    abort_test();
    reset_mid_test();
    run_burst(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
